// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared defaults, the route record and its reset (identity) value
package crossbar_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ROUTE_SEL_W = 8;
  typedef struct packed {
    logic en;
    logic [ROUTE_SEL_W-1:0] sel;
  } route_t;
  function automatic route_t reset_route(input int o, input int num_in);
    route_t r;
    r.en = o < num_in;
    r.sel = r.en ? ROUTE_SEL_W'(o) : '0;
    return r;
  endfunction
endpackage

// File: rtl/xbar_out_stage.sv
// xbar_out_stage: one output's route register (cfg_we/cfg_sel/cfg_en) and valid/ready output register (load/load_data -> out_data/out_valid, out_ready), exporting route_en/route_sel/can_load
module xbar_out_stage
  import crossbar_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W = 2,
  parameter int IDX = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [SEL_W-1:0]       cfg_sel,
  input  logic                   cfg_en,
  input  logic                   load,
  input  logic [DATA_W-1:0]      load_data,
  input  logic                   out_ready,
  output logic                   route_en,
  output logic [ROUTE_SEL_W-1:0] route_sel,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   can_load
);
  route_t route_q, route_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d;
  always_comb begin
    can_load = !valid_q || out_ready;
    route_d = cfg_we ? '{en: cfg_en, sel: ROUTE_SEL_W'(cfg_sel)} : route_q;
    data_d = load ? load_data : data_q;
    valid_d = load || (valid_q && !out_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      route_q <= reset_route(IDX, NUM_IN);
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      route_q <= route_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
  assign route_en = route_q.en && route_q.sel < ROUTE_SEL_W'(NUM_IN);
  assign route_sel = route_q.sel;
  assign out_data = data_q;
  assign out_valid = valid_q;
endmodule

// File: rtl/crossbar_switch_nxm.sv
// crossbar_switch_nxm: NUM_IN x NUM_OUT multicast crossbar; in_* valid/ready inputs, out_* registered valid/ready outputs, cfg_* per-output route writes
module crossbar_switch_nxm
  import crossbar_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int NUM_OUT = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W = $clog2(NUM_IN),
  parameter int PORT_W = $clog2(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [PORT_W-1:0]         cfg_port,
  input  logic [SEL_W-1:0]          cfg_sel,
  input  logic                      cfg_en
);
  logic [NUM_OUT-1:0] route_en, can_load, load, cfg_we;
  logic [ROUTE_SEL_W-1:0] route_sel [NUM_OUT];
  logic [DATA_W-1:0] load_data [NUM_OUT];
  logic [NUM_IN-1:0] routed, blocked;
  always_comb begin
    routed = '0;
    blocked = '0;
    load = '0;
    cfg_we = '0;
    for (int o = 0; o < NUM_OUT; o++) load_data[o] = '0;
    for (int o = 0; o < NUM_OUT; o++)
      for (int i = 0; i < NUM_IN; i++)
        if (route_en[o] && route_sel[o] == ROUTE_SEL_W'(i)) begin
          routed[i] = 1'b1;
          blocked[i] = blocked[i] || !can_load[o];
        end
    in_ready = routed & ~blocked;
    // each output has exactly one source, so at most one input drives any load
    for (int o = 0; o < NUM_OUT; o++)
      for (int i = 0; i < NUM_IN; i++)
        if (route_en[o] && route_sel[o] == ROUTE_SEL_W'(i) && in_valid[i] && in_ready[i]) begin
          load[o] = 1'b1;
          load_data[o] = in_data[i*DATA_W +: DATA_W];
        end
    cfg_ready = (32'(cfg_port) >= NUM_OUT) || !out_valid[cfg_port];
    for (int o = 0; o < NUM_OUT; o++) cfg_we[o] = cfg_valid && cfg_ready && cfg_port == PORT_W'(o);
  end
  for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
    xbar_out_stage #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .SEL_W(SEL_W), .IDX(o)) u_stage (
      .clk(clk),
      .rst(rst),
      .cfg_we(cfg_we[o]),
      .cfg_sel(cfg_sel),
      .cfg_en(cfg_en),
      .load(load[o]),
      .load_data(load_data[o]),
      .out_ready(out_ready[o]),
      .route_en(route_en[o]),
      .route_sel(route_sel[o]),
      .out_data(out_data[o*DATA_W +: DATA_W]),
      .out_valid(out_valid[o]),
      .can_load(can_load[o])
    );
  end
endmodule

// File: tb/tb_crossbar_switch_nxm.sv
// tb_crossbar_switch_nxm: directed tests plus a per-output scoreboard for the 4x4 crossbar
module tb_crossbar_switch_nxm;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] in_data;
  logic [3:0] in_valid, in_ready, out_valid, out_ready;
  logic [31:0] out_data;
  logic cfg_valid, cfg_ready, cfg_en;
  logic [1:0] cfg_port, cfg_sel;
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] sbq [N][$];
  logic m_en [N];
  logic [1:0] m_sel [N];
  crossbar_switch_nxm dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_port(cfg_port),
    .cfg_sel(cfg_sel), .cfg_en(cfg_en)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      for (int o = 0; o < N; o++) begin
        sbq[o].delete();
        m_en[o] = 1'b1;
        m_sel[o] = 2'(o);
      end
    end else begin
      for (int o = 0; o < N; o++)
        if (out_valid[o] && out_ready[o]) begin
          if (sbq[o].size() == 0) check($sformatf("sb_out%0d_unexpected_qsize", o), 32'(sbq[o].size()), 32'd1);
          else check($sformatf("sb_out%0d", o), 32'(out_data[o*8 +: 8]), 32'(sbq[o].pop_front()));
        end
      for (int i = 0; i < N; i++)
        if (in_valid[i] && in_ready[i])
          for (int o = 0; o < N; o++)
            if (m_en[o] && m_sel[o] == 2'(i)) sbq[o].push_back(in_data[i*8 +: 8]);
      if (cfg_valid && cfg_ready) begin
        m_en[cfg_port] = cfg_en;
        m_sel[cfg_port] = cfg_sel;
      end
    end
  end
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg_write(input logic [1:0] port, input logic [1:0] sel, input logic en);
    int k;
    k = 0;
    cfg_valid = 1'b1;
    cfg_port = port;
    cfg_sel = sel;
    cfg_en = en;
    @(negedge clk);
    while (!cfg_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("cfg_accept", 32'(cfg_ready), 32'd1);
    sync();
    cfg_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [4:0] pat;
    int sent;
    int left;
    rst = 1'b1;
    in_data = '0;
    in_valid = '0;
    out_ready = 4'hF;
    cfg_valid = 1'b0;
    cfg_port = '0;
    cfg_sel = '0;
    cfg_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'hF);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    sync();
    in_data[15:8] = 8'h5A;
    in_valid = 4'b0010;
    @(negedge clk);
    check("t1_in_ready", 32'(in_ready[1]), 32'd1);
    sync();
    in_valid = '0;
    @(negedge clk);
    check("t1_out_valid", 32'(out_valid), 32'b0010);
    check("t1_out_data", 32'(out_data[15:8]), 32'h5A);
    @(negedge clk);
    check("t1_drained", 32'(out_valid), 32'h0);
    sync();
    cfg_write(2'd0, 2'd2, 1'b1);
    cfg_write(2'd3, 2'd2, 1'b1);
    out_ready = 4'b0111;
    in_data[23:16] = 8'hC3;
    in_valid = 4'b0100;
    @(negedge clk);
    check("t2_first_fire", 32'(in_ready[2]), 32'd1);
    sync();
    in_data[23:16] = 8'hC4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_blocked", 32'(in_ready[2]), 32'd0);
      if (k == 0) check("t2_mcast_valid", 32'(out_valid), 32'b1101);
      sync();
    end
    out_ready = 4'hF;
    @(negedge clk);
    check("t2_unblocked", 32'(in_ready[2]), 32'd1);
    sync();
    in_valid = '0;
    @(negedge clk);
    check("t2_second_valid", 32'(out_valid), 32'b1101);
    check("t2_second_data", 32'(out_data[7:0]), 32'hC4);
    @(negedge clk);
    check("t2_drained", 32'(out_valid), 32'h0);
    sync();
    cfg_write(2'd0, 2'd0, 1'b1);
    cfg_write(2'd3, 2'd3, 1'b1);
    pat = 5'b11101;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      out_ready[0] = (c < 5) ? pat[c] : 1'b1;
      in_valid[0] = sent < 4;
      in_data[7:0] = 8'(sent + 1);
      @(negedge clk);
      if (c < 5) check("t3_in_ready", 32'(in_ready[0]), 32'(pat[c]));
      if (in_valid[0] && in_ready[0]) sent++;
      sync();
    end
    in_valid = '0;
    check("t3_sent", 32'(sent), 32'd4);
    @(negedge clk);
    check("t3_drained", 32'(out_valid[0]), 32'd0);
    sync();
    out_ready[1] = 1'b0;
    in_data[15:8] = 8'h11;
    in_valid = 4'b0010;
    @(negedge clk);
    sync();
    in_valid = '0;
    cfg_valid = 1'b1;
    cfg_port = 2'd1;
    cfg_sel = 2'd3;
    cfg_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t4_cfg_blocked", 32'(cfg_ready), 32'd0);
      check("t4_out1_full", 32'(out_valid[1]), 32'd1);
      sync();
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    check("t4_cfg_blocked_drain", 32'(cfg_ready), 32'd0);
    sync();
    @(negedge clk);
    check("t4_cfg_ready", 32'(cfg_ready), 32'd1);
    sync();
    cfg_valid = 1'b0;
    in_data[31:24] = 8'h77;
    in_valid = 4'b1000;
    @(negedge clk);
    check("t4_in3_ready", 32'(in_ready[3]), 32'd1);
    sync();
    in_valid = '0;
    @(negedge clk);
    check("t4_out_valid", 32'(out_valid), 32'b1010);
    check("t4_out1_data", 32'(out_data[15:8]), 32'h77);
    sync();
    cfg_write(2'd1, 2'd1, 1'b1);
    cfg_write(2'd0, 2'd0, 1'b0);
    in_data[7:0] = 8'hAA;
    in_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_in_ready", 32'(in_ready[0]), 32'd0);
      check("t5_out_valid", 32'(out_valid[0]), 32'd0);
      sync();
    end
    in_valid = '0;
    cfg_write(2'd0, 2'd0, 1'b1);
    cfg_write(2'd1, 2'd0, 1'b1);
    out_ready = 4'h0;
    in_data = 32'h44332211;
    in_valid = 4'hF;
    @(negedge clk);
    check("t6_in1_unrouted", 32'(in_ready[1]), 32'd0);
    sync();
    in_valid = '0;
    @(negedge clk);
    check("t6_full", 32'(out_valid), 32'hF);
    check("t6_full_data", out_data, 32'h44331111);
    sync();
    rst = 1'b1;
    @(negedge clk);
    sync();
    rst = 1'b0;
    out_ready = 4'hF;
    @(negedge clk);
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    check("t6_rst_data", out_data, 32'h0);
    check("t6_rst_in_ready", 32'(in_ready), 32'hF);
    sync();
    in_data[15:8] = 8'h3C;
    in_valid = 4'b0010;
    @(negedge clk);
    sync();
    in_valid = '0;
    @(negedge clk);
    check("t6_identity_valid", 32'(out_valid), 32'b0010);
    check("t6_identity_data", 32'(out_data[15:8]), 32'h3C);
    repeat (2) @(negedge clk);
    left = 0;
    for (int o = 0; o < N; o++) left += sbq[o].size();
    check("sb_leftover", 32'(left), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
